// File: rtl/mux_lut_logic_unit.sv
// Bitwise programmable 2-input logic unit: a 4-entry truth table drives a per-bit mux tree.
// Results go into a 2-entry output queue. Optional MUX_LUT_REDUCE_EN adds per-entry OR/AND reductions.
module mux_lut_logic_unit #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [3:0]         cfg_tt,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [3:0]         out_tt,
    output logic [COUNT_W-1:0] txn_count
`ifdef MUX_LUT_REDUCE_EN
    ,
    output logic               out_any,
    output logic               out_all
`endif
);

    logic [3:0]       tt;
    logic [1:0]       count;
    logic [WIDTH-1:0] data0, data1;
    logic [3:0]       tt0, tt1;
    logic [WIDTH-1:0] result;
    logic             push, pop;

    // Level 1 selects on b, level 2 selects on a, so r = tt[{a,b}].
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic m0, m1;
        assign m0 = in_b[gi] ? tt[1] : tt[0];
        assign m1 = in_b[gi] ? tt[3] : tt[2];
        assign result[gi] = in_a[gi] ? m1 : m0;
    end

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = data0;
    assign out_tt    = tt0;

`ifdef MUX_LUT_REDUCE_EN
    logic any0, any1, all0, all1;
    assign out_any = any0;
    assign out_all = all0;

    // Reductions are captured with the entry so they always match its data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any0 <= 1'b0;
            all0 <= 1'b0;
            any1 <= 1'b0;
            all1 <= 1'b0;
        end else begin
            if (push && (count == 2'd0 || (count == 2'd1 && pop))) begin
                any0 <= |result;
                all0 <= &result;
            end else if (push && count == 2'd1) begin
                any1 <= |result;
                all1 <= &result;
            end else if (pop && count == 2'd2) begin
                any0 <= any1;
                all0 <= all1;
            end
        end
    end
`endif

    // Slot 0 is always the queue head; slot 1 shifts down on a pop from a full queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tt        <= 4'b1000;
            count     <= 2'd0;
            data0     <= '0;
            data1     <= '0;
            tt0       <= 4'b0000;
            tt1       <= 4'b0000;
            txn_count <= '0;
        end else begin
            if (cfg_we) begin
                tt <= cfg_tt;
            end
            if (pop) begin
                txn_count <= txn_count + 1'b1;
            end
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        data0 <= result;
                        tt0   <= tt;
                    end else begin
                        data1 <= result;
                        tt1   <= tt;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        data0 <= data1;
                        tt0   <= tt1;
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    data0 <= result;
                    tt0   <= tt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_lut_logic_unit.sv
// Scoreboard bench for mux_lut_logic_unit: the driver queues expected results, a negedge monitor checks them.
// Builds with or without MUX_LUT_REDUCE_EN.
module tb_mux_lut_logic_unit;

    localparam int WIDTH   = 8;
    localparam int COUNT_W = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cfg_we = 1'b0;
    logic [3:0]         cfg_tt = 4'b0000;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a = '0;
    logic [WIDTH-1:0]   in_b = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [WIDTH-1:0]   out_data;
    logic [3:0]         out_tt;
    logic [COUNT_W-1:0] txn_count;
`ifdef MUX_LUT_REDUCE_EN
    logic               out_any;
    logic               out_all;
`endif

    mux_lut_logic_unit #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_tt(cfg_tt),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tt(out_tt), .txn_count(txn_count)
`ifdef MUX_LUT_REDUCE_EN
        , .out_any(out_any), .out_all(out_all)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [3:0]       tt;
    } exp_t;

    exp_t               sb[$];
    int                 errors = 0;
    int                 checks = 0;
    logic [3:0]         model_tt = 4'b1000;
    int                 occ = 0;
    logic [COUNT_W-1:0] exp_count = '0;

    // Reference: look up the truth table entry addressed by {a,b} for each bit position.
    function automatic logic [WIDTH-1:0] ref_fn(input logic [3:0] t, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = t[2 * int'(a[i]) + int'(b[i])];
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic we, input logic [3:0] t, input logic ordy,
                                 output logic acc);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        cfg_we    = we;
        cfg_tt    = t;
        out_ready = ordy;
        @(negedge clk);
        acc = v && in_ready;
        if (acc) begin
            e.data = ref_fn(model_tt, a, b);
            e.tt   = model_tt;
            sb.push_back(e);
        end
        if (we) model_tt = t;
    endtask

    task automatic pushOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ordy);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            applyStimulus(1'b1, a, b, 1'b0, 4'b0000, ordy, acc);
        end
        if (!acc) begin
            errors++;
            $display("[TB] FAIL push_timeout: operands %0h/%0h never accepted", a, b);
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        logic acc;
        for (int k = 0; k < n; k++) applyStimulus(1'b0, '0, '0, 1'b0, 4'b0000, ordy, acc);
    endtask

    // Monitor: checks handshake state against the occupancy model and pops the scoreboard on each output handshake.
    always @(negedge clk) begin
        exp_t e;
        logic model_push, model_pop;
        if (rst) begin
            sb.delete();
            occ       = 0;
            exp_count = '0;
        end else begin
            checkOutput("out_valid", int'(out_valid), int'(occ > 0));
            checkOutput("in_ready", int'(in_ready), int'(occ < 2));
            checkOutput("txn_count", int'(txn_count), int'(exp_count));
            model_push = in_valid && (occ < 2);
            model_pop  = out_ready && (occ > 0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    errors++;
                    checks++;
                    $display("[TB] FAIL unexpected_output: data %0h with empty scoreboard", out_data);
                end else begin
                    e = sb.pop_front();
                    checkOutput("out_data", int'(out_data), int'(e.data));
                    checkOutput("out_tt", int'(out_tt), int'(e.tt));
`ifdef MUX_LUT_REDUCE_EN
                    checkOutput("out_any", int'(out_any), int'(e.data != '0));
                    checkOutput("out_all", int'(out_all), int'(e.data == '1));
`endif
                end
            end
            if (model_pop) exp_count = exp_count + 1'b1;
            occ = occ + int'(model_push) - int'(model_pop);
        end
    end

    initial begin
        logic acc;
        logic [WIDTH-1:0] ra, rb;
        #12;
        rst = 1'b0;
        #1;
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_out_data", int'(out_data), 0);
        checkOutput("reset_out_tt", int'(out_tt), 0);
        checkOutput("reset_txn_count", int'(txn_count), 0);
        checkOutput("reset_in_ready", int'(in_ready), 1);

        // Default AND table, then XOR, then a table write racing a push.
        pushOp(8'hF0, 8'hCC, 1'b1);
        idle(2, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b1, 4'b0110, 1'b1, acc);
        pushOp(8'hAA, 8'h0F, 1'b1);
        applyStimulus(1'b1, 8'h01, 8'h02, 1'b1, 4'b1110, 1'b1, acc);
        checkOutput("same_cycle_cfg_accept", int'(acc), 1);
        idle(2, 1'b1);

        // Reduction corner cases under OR.
        pushOp(8'h00, 8'h00, 1'b1);
        pushOp(8'hFF, 8'h00, 1'b1);
        idle(2, 1'b1);

        // Backpressure: third operand must wait while the queue is full.
        pushOp(8'h12, 8'h34, 1'b0);
        pushOp(8'h56, 8'h78, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 8'h9A, 8'hBC, 1'b0, 4'b0000, 1'b0, acc);
            checkOutput("full_blocks_input", int'(acc), 0);
        end
        applyStimulus(1'b1, 8'h9A, 8'hBC, 1'b0, 4'b0000, 1'b1, acc);
        checkOutput("full_blocks_with_out_ready", int'(acc), 0);
        pushOp(8'h9A, 8'hBC, 1'b1);
        idle(4, 1'b1);

        // Streaming at occupancy 1: one in, one out every cycle.
        pushOp(8'h3C, 8'h5A, 1'b0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, WIDTH'(k * 17), WIDTH'(k * 29 + 3), 1'b0, 4'b0000, 1'b1, acc);
            checkOutput("stream_accept", int'(acc), 1);
        end
        idle(3, 1'b1);

        // Randomised traffic with occasional table rewrites.
        for (int k = 0; k < 300; k++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            applyStimulus(1'($urandom_range(0, 1)), ra, rb, ($urandom_range(0, 7) == 0),
                          4'($urandom), 1'($urandom_range(0, 1)), acc);
        end
        idle(4, 1'b1);

        // Asynchronous reset with two entries queued.
        pushOp(8'hFF, 8'h0F, 1'b0);
        pushOp(8'hF0, 8'h3C, 1'b0);
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_out_valid", int'(out_valid), 0);
        checkOutput("async_rst_out_data", int'(out_data), 0);
        checkOutput("async_rst_out_tt", int'(out_tt), 0);
        checkOutput("async_rst_txn_count", int'(txn_count), 0);
        model_tt = 4'b1000;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", int'(in_ready), 1);
        pushOp(8'hF0, 8'hCC, 1'b1);
        idle(2, 1'b1);

        for (int k = 0; k < 50 && sb.size() != 0; k++) idle(1, 1'b1);
        checkOutput("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
